// File: rtl/ripple_count_monitor_if.sv
// rtl/ripple_count_monitor_if.sv - counter pins in, clean count and step events out
interface ripple_count_monitor_if #(
    parameter int ERR_W = 8
);
    logic             m;
    logic             qa;
    logic             qb;
    logic             qc;
    logic             err_clr;
    logic [2:0]       count;
    logic             count_valid;
    logic             step_up;
    logic             step_down;
    logic             wrap;
    logic             step_err;
    logic             dir_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output m, qa, qb, qc, err_clr,
        input  count, count_valid, step_up, step_down, wrap, step_err, dir_err, err_cnt
    );

    modport slave (
        input  m, qa, qb, qc, err_clr,
        output count, count_valid, step_up, step_down, wrap, step_err, dir_err, err_cnt
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - sync, deglitch and classify steps of a 3-bit ripple counter
module ripple_count_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_count_monitor_if.slave bus
);
    typedef enum logic {S_INIT, S_TRACK} state_t;

    localparam logic [4:0] STAB_N = 5'(STABLE_CYCLES);

    logic [2:0]       r_q_s1, r_q_s2;
    logic             r_m_s1, r_m_s2, r_m_last, r_grace;
    logic [1:0]       r_sync_vld;
    logic [2:0]       r_cand;
    logic             r_cand_vld, r_fired;
    logic [3:0]       r_stab;
    state_t           r_state;
    logic [2:0]       r_count;
    logic             r_count_valid, r_step_up, r_step_down, r_wrap, r_step_err, r_dir_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_filt_en, w_new, w_accept, w_grace, w_step, w_err;
    logic [4:0]       w_stab_inc;
    logic [2:0]       w_plus, w_minus;
    state_t           w_state_n;
    logic [2:0]       w_count_n;
    logic             w_valid_n, w_up_n, w_down_n, w_wrap_n, w_serr_n, w_derr_n;

    // The sync chain holds reset zeros for two edges; the filter ignores them.
    assign w_filt_en  = r_sync_vld[1];
    assign w_new      = !r_cand_vld || (r_q_s2 != r_cand);
    assign w_stab_inc = {1'b0, r_stab} + 5'd1;
    assign w_accept   = w_filt_en &&
                        (w_new ? (STABLE_CYCLES == 1) : (!r_fired && (w_stab_inc >= STAB_N)));
    assign w_grace    = r_grace || (r_m_s2 != r_m_last);
    assign w_plus     = r_count + 3'd1;
    assign w_minus    = r_count - 3'd1;
    assign w_err      = r_step_err || r_dir_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_s1     <= 3'd0;
            r_q_s2     <= 3'd0;
            r_m_s1     <= 1'b0;
            r_m_s2     <= 1'b0;
            r_m_last   <= 1'b0;
            r_sync_vld <= 2'b00;
            r_cand     <= 3'd0;
            r_cand_vld <= 1'b0;
            r_fired    <= 1'b0;
            r_stab     <= 4'd0;
        end else begin
            r_q_s1     <= {bus.qc, bus.qb, bus.qa};
            r_q_s2     <= r_q_s1;
            r_m_s1     <= bus.m;
            r_m_s2     <= r_m_s1;
            r_m_last   <= r_m_s2;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (w_filt_en) begin
                if (w_new) begin
                    r_cand     <= r_q_s2;
                    r_cand_vld <= 1'b1;
                    r_stab     <= 4'd1;
                    r_fired    <= w_accept;
                end else if (!r_fired) begin
                    r_stab  <= w_stab_inc[3:0];
                    r_fired <= w_accept;
                end
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_count_n = r_count;
        w_valid_n = r_count_valid;
        w_up_n    = 1'b0;
        w_down_n  = 1'b0;
        w_wrap_n  = 1'b0;
        w_serr_n  = 1'b0;
        w_derr_n  = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (w_accept) begin
                    w_count_n = r_q_s2;
                    w_valid_n = 1'b1;
                    w_state_n = S_TRACK;
                end
            end
            S_TRACK: begin
                if (w_accept && (r_q_s2 != r_count)) begin
                    w_step    = 1'b1;
                    w_count_n = r_q_s2;
                    if (r_q_s2 == w_plus) begin
                        w_up_n   = 1'b1;
                        w_wrap_n = (r_count == 3'd7);
                        w_derr_n = r_m_s2 && !w_grace;
                    end else if (r_q_s2 == w_minus) begin
                        w_down_n = 1'b1;
                        w_wrap_n = (r_count == 3'd0);
                        w_derr_n = !r_m_s2 && !w_grace;
                    end else begin
                        w_serr_n = 1'b1;
                    end
                end
            end
            default: w_state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_INIT;
            r_count       <= 3'd0;
            r_count_valid <= 1'b0;
            r_step_up     <= 1'b0;
            r_step_down   <= 1'b0;
            r_wrap        <= 1'b0;
            r_step_err    <= 1'b0;
            r_dir_err     <= 1'b0;
            r_grace       <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_count       <= w_count_n;
            r_count_valid <= w_valid_n;
            r_step_up     <= w_up_n;
            r_step_down   <= w_down_n;
            r_wrap        <= w_wrap_n;
            r_step_err    <= w_serr_n;
            r_dir_err     <= w_derr_n;
            r_grace       <= w_step ? 1'b0 : w_grace;
        end
    end

    // Counts the cycle an error pulse is visible, so a clear in that cycle keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= ERR_W'(w_err);
        end else if (w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.count       = r_count;
    assign bus.count_valid = r_count_valid;
    assign bus.step_up     = r_step_up;
    assign bus.step_down   = r_step_down;
    assign bus.wrap        = r_wrap;
    assign bus.step_err    = r_step_err;
    assign bus.dir_err     = r_dir_err;
    assign bus.err_cnt     = r_err_cnt;
endmodule
